// File: rtl/mem_access_stage_pkg.sv
// Shared word width, FSM state encodings and the captured-request record
// used by the memory-access stage and its data memory.
package mem_access_stage_pkg;

    localparam int WORD = 64;

    localparam logic [1:0] MEM_IDLE = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] MEM_DONE = 2'd2;

    typedef struct packed {
        logic [WORD-1:0] alu_result;
        logic [WORD-1:0] read_data2;
        logic [WORD-1:0] branch_target;
        logic            zero;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            uncond_branch;
        logic            mem_to_reg;
    } mem_req_t;

endpackage

// File: rtl/mem_access_stage_data_memory.sv
// Word-addressed data memory: synchronous write, registered read, and a
// synchronous clear that zeroes every word and the read register.
module data_memory
    import mem_access_stage_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            we,
    input  logic            re,
    input  logic [AW-1:0]   addr,
    input  logic [WORD-1:0] wdata,
    output logic [WORD-1:0] rdata
);

    logic [WORD-1:0] mem_reg [DEPTH];
    logic [WORD-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            rdata_reg <= '0;
        end else begin
            if (we) begin
                mem_reg[addr] <= wdata;
            end
            if (re) begin
                rdata_reg <= mem_reg[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: captures execute results, resolves the branch, runs
// LDUR/STUR with MEM_LAT wait states, and presents one result per out_valid.
// Optional feature macro: MEM_ALIGN_CHECK_EN (fault on nonzero byte offset).
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DMEM_DEPTH = 64,
    parameter int MEM_LAT    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] read_data2,
    input  logic [WORD-1:0] branch_target,
    input  logic            zero,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            uncond_branch,
    input  logic            mem_to_reg,
    output logic            out_valid,
    output logic [WORD-1:0] wb_data,
    output logic            pc_src,
    output logic [WORD-1:0] pc_branch,
    output logic            misaligned
);

    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [1:0]      state_reg;
    logic [3:0]      cnt_reg;
    mem_req_t        req_reg;
    logic            load_valid_reg;

    logic            access;
    logic            in_range;
    logic            addr_fault;
    logic            do_write;
    logic            do_read;
    logic [WORD-1:0] mem_rdata;

    assign in_range = (req_reg.alu_result >> 3) < WORD'(DMEM_DEPTH);

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_fault = (req_reg.mem_read | req_reg.mem_write) & (|req_reg.alu_result[2:0]);
`else
    assign addr_fault = 1'b0;
`endif

    // The access happens on the edge that leaves WAIT; faults and
    // out-of-range addresses simply suppress the memory strobes.
    always_comb begin
        access   = (state_reg == MEM_WAIT) && (cnt_reg == 4'd0);
        do_write = access & req_reg.mem_write & in_range & ~addr_fault;
        do_read  = access & req_reg.mem_read & ~req_reg.mem_write & in_range & ~addr_fault;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= MEM_IDLE;
            cnt_reg        <= '0;
            req_reg        <= '0;
            load_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                MEM_IDLE: begin
                    if (in_valid) begin
                        req_reg.alu_result    <= alu_result;
                        req_reg.read_data2    <= read_data2;
                        req_reg.branch_target <= branch_target;
                        req_reg.zero          <= zero;
                        req_reg.mem_read      <= mem_read;
                        req_reg.mem_write     <= mem_write;
                        req_reg.branch        <= branch;
                        req_reg.uncond_branch <= uncond_branch;
                        req_reg.mem_to_reg    <= mem_to_reg;
                        load_valid_reg        <= 1'b0;
                        if (mem_read || mem_write) begin
                            state_reg <= MEM_WAIT;
                            cnt_reg   <= 4'(MEM_LAT - 1);
                        end else begin
                            state_reg <= MEM_DONE;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg      <= MEM_DONE;
                        load_valid_reg <= do_read;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                MEM_DONE: begin
                    state_reg <= MEM_IDLE;
                end
                default: begin
                    state_reg <= MEM_IDLE;
                end
            endcase
        end
    end

    data_memory #(
        .DEPTH (DMEM_DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .clr   (reset),
        .we    (do_write),
        .re    (do_read),
        .addr  (req_reg.alu_result[3 +: AW]),
        .wdata (req_reg.read_data2),
        .rdata (mem_rdata)
    );

    assign in_ready  = (state_reg == MEM_IDLE);
    assign out_valid = (state_reg == MEM_DONE);
    assign pc_src    = req_reg.uncond_branch | (req_reg.branch & req_reg.zero);
    assign pc_branch = req_reg.branch_target;
    assign misaligned = out_valid & addr_fault;

    // Read register only holds meaningful data when this op actually read.
    always_comb begin
        wb_data = req_reg.alu_result;
        if (req_reg.mem_to_reg) begin
            wb_data = load_valid_reg ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (DMEM_DEPTH=64, MEM_LAT=2).
// Honours MEM_ALIGN_CHECK_EN for the misaligned-load expectation.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] alu_result;
    logic [63:0] read_data2;
    logic [63:0] branch_target;
    logic        zero;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        uncond_branch;
    logic        mem_to_reg;
    logic        out_valid;
    logic [63:0] wb_data;
    logic        pc_src;
    logic [63:0] pc_branch;
    logic        misaligned;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [63:0] obs_wb;
    logic        obs_pc_src;
    logic [63:0] obs_pcb;
    logic        obs_mis;
    logic        obs_rdy;
    int          lat;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DMEM_DEPTH (64),
        .MEM_LAT    (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .read_data2    (read_data2),
        .branch_target (branch_target),
        .zero          (zero),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch        (branch),
        .uncond_branch (uncond_branch),
        .mem_to_reg    (mem_to_reg),
        .out_valid     (out_valid),
        .wb_data       (wb_data),
        .pc_src        (pc_src),
        .pc_branch     (pc_branch),
        .misaligned    (misaligned)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; alu_result = '0; read_data2 = '0; branch_target = '0;
        zero = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
        uncond_branch = 1'b0; mem_to_reg = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // Issue one op, then report edges from accept to out_valid (lat) and
    // the result fields seen while out_valid is high.
    task automatic do_op(input logic [63:0] alu, input logic [63:0] data, input logic [63:0] tgt,
                         input logic z, input logic mr, input logic mw, input logic br,
                         input logic ub, input logic m2r);
        int n;
        wait_ready();
        alu_result = alu; read_data2 = data; branch_target = tgt; zero = z;
        mem_read = mr; mem_write = mw; branch = br; uncond_branch = ub; mem_to_reg = m2r;
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        obs_rdy = in_ready;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        lat = out_valid ? n : -1;
        obs_wb = wb_data; obs_pc_src = pc_src; obs_pcb = pc_branch; obs_mis = misaligned;
        @(posedge clk); #1;
        check("pulse_one_cycle", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int seen;
        reset = 1'b1;
        clear_inputs();
        do_reset();
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_pc_src", 64'(pc_src), 64'd0);
        check("rst_pc_branch", pc_branch, 64'd0);
        check("rst_misaligned", 64'(misaligned), 64'd0);

        // Non-memory pass-through
        do_op(64'h2A, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu_lat", 64'(lat), 64'd1);
        check("alu_wb", obs_wb, 64'h2A);
        check("alu_pc_src", 64'(obs_pc_src), 64'd0);

        // STUR then LDUR at 0x10
        do_op(64'h10, 64'hDEADBEEF, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("stur_lat", 64'(lat), 64'd3);
        check("stur_ready_in_wait", 64'(obs_rdy), 64'd0);
        do_op(64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ldur_lat", 64'(lat), 64'd3);
        check("ldur_wb", obs_wb, 64'hDEADBEEF);

        // Branches
        do_op(64'h0, 64'h0, 64'h40, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cbz_taken_src", 64'(obs_pc_src), 64'd1);
        check("cbz_taken_pcb", obs_pcb, 64'h40);
        do_op(64'h0, 64'h0, 64'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("cbz_not_taken", 64'(obs_pc_src), 64'd0);
        check("cbz_not_taken_pcb", obs_pcb, 64'h80);
        do_op(64'h0, 64'h0, 64'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("uncond_src", 64'(obs_pc_src), 64'd1);

        // Out-of-range store must not alias onto word 0
        do_op(64'h0, 64'h55, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(64'h200, 64'h1234, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("oor_store_lat", 64'(lat), 64'd3);
        do_op(64'h200, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("oor_load_zero", obs_wb, 64'h0);
        do_op(64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("addr0_unmodified", obs_wb, 64'h55);

        // Read and write together: store happens, load data is 0
        do_op(64'h20, 64'h77, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("rw_both_wb", obs_wb, 64'h0);
        do_op(64'h20, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rw_both_stored", obs_wb, 64'h77);

        // Reset during WAIT of a store to 0x18
        wait_ready();
        alu_result = 64'h18; read_data2 = 64'hABCD; mem_write = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
            if (i == 1) reset = 1'b0;
        end
        check("rst_mid_no_valid", 64'(seen), 64'd0);
        do_op(64'h18, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_mid_load18", obs_wb, 64'h0);
        do_op(64'h10, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_cleared_0x10", obs_wb, 64'h0);

        // Byte-offset load from 0x13
        do_op(64'h10, 64'hCAFE, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(64'h13, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("mis_lat", 64'(lat), 64'd3);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_flag", 64'(obs_mis), 64'd1);
        check("mis_wb", obs_wb, 64'h0);
`else
        check("mis_flag", 64'(obs_mis), 64'd0);
        check("mis_wb", obs_wb, 64'hCAFE);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
